adc_capture: RTL
================

Name: adc_capture

Overview:
- Receive-side counterpart of the NCO/DAC transmit path.
- Registers the 14-bit offset-binary samples from one ADC port (for example ADC_DA) and converts them to two's complement.
- Waits for a level-crossing trigger, stores a fixed-length record in on-chip RAM, then streams the record out over a valid/ready read port.
- Runs in the ADC clock domain (CLK_65). The ADC_OTR overrange pin is tracked as a sticky flag.

Parameters:
DATA_W, 14, ADC sample width in bits.
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples.

Ports:
clk  in  1  sample clock, connected to CLK_65; all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
adc_data  in  DATA_W  raw offset-binary ADC word
adc_otr  in  1  ADC overrange pin
arm  in  1  single-cycle request to arm a capture
trig_level  in  DATA_W  signed trigger threshold
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
capture_len  in  ADDR_W+1  record length in samples, latched on arm
otr_clear  in  1  clears otr_sticky
busy  out  1  high in ARMED, CAPTURE and READOUT
done  out  1  one-cycle pulse when the last sample is accepted by the reader
otr_sticky  out  1  an overrange occurred during CAPTURE
rd_data  out  DATA_W  signed sample
rd_valid  out  1  rd_data is valid
rd_ready  in  1  reader accepts the sample
rd_last  out  1  marks the final sample of the record

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE. busy, done, otr_sticky, rd_valid and rd_last = 0; rd_data = 0. Pointers and the previous-sample register = 0.
- Input stage (register s0): s0 = {~adc_data[13], adc_data[12:0]}, i.e. offset binary to two's complement. Raw 0x0000 becomes -8192; 0x3FFF becomes +8191.
  - s0_prev holds the s0 value from the previous cycle.
  - Input latency from pin to s0 is 1 cycle.
- Trigger:
  - Rising: s0_prev < trig_level AND s0 >= trig_level (signed compare).
  - Falling: s0_prev > trig_level AND s0 <= trig_level.
  - A sample exactly equal to the level with s0_prev also equal does not trigger.
- State machine:
  - IDLE: arm=1 latches len_q = capture_len, then goes to ARMED. If capture_len = 0 or capture_len > DEPTH, len_q = DEPTH.
  - ARMED: the first cycle with a trigger goes to CAPTURE. The triggering s0 is written to address 0 in that same cycle, and wr_cnt = 1.
  - CAPTURE: each cycle writes s0 to address wr_cnt and increments wr_cnt. When the write with wr_cnt = len_q-1 completes, go to READOUT. If len_q = 1, go directly from ARMED to READOUT.
  - READOUT: streams addresses 0..len_q-1 in order.
    - RAM read latency is 1 cycle; a prefetch/skid register keeps throughput at 1 sample/cycle while rd_ready=1.
    - rd_valid asserts 1 or 2 cycles after READOUT entry.
    - While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
    - rd_last = 1 together with sample len_q-1.
    - On the handshake of the last sample: done = 1 for 1 cycle, go to IDLE, rd_valid drops.
- arm while not in IDLE is ignored.
- rd_ready is ignored while rd_valid=0.
- otr_sticky: set when adc_otr=1 is registered during CAPTURE, including the trigger cycle. Cleared by otr_clear. If set and clear coincide, set wins. Also cleared on arm.
- There is no abort input; only reset_n stops a capture. Reset asserted mid-operation returns to IDLE immediately, and RAM contents are not cleared.
- The free-running input stage keeps s0_prev valid in every state, so re-arming immediately after done is legal.

Optional Feature:
- Macro ADC_FORCE_TRIG_EN.
- Defined: adds input port force_trig (1 bit). force_trig=1 in ARMED acts as a trigger in that cycle regardless of level, with the current s0 stored at address 0. force_trig in any other state is ignored.
- Undefined: the force_trig port and its logic are absent; only the level trigger can start a capture.

Test Plan:
- Reset release, idle inputs -> busy=0, rd_valid=0, done=0, otr_sticky=0.
- capture_len=8, rising level 0, arm, then adc_data ramps 0x1FF0, 0x1FF1, ... -> trigger when raw crosses 0x2000. rd_data reads 0,1,...,7 with rd_last on the 8th, and done pulses once.
- trig_falling=1, level -100, sine input, capture_len=0 -> 1024 samples read back. The first sample is <= -100 and the previous input sample was > -100.
- Reader backpressure: rd_ready toggles 1,0,0,1 in a repeating pattern -> no sample is lost or duplicated, and rd_data is stable while stalled.
- adc_otr pulsed for 1 cycle during CAPTURE -> otr_sticky=1 until otr_clear. adc_otr pulsed in IDLE -> otr_sticky stays 0.
- reset_n asserted mid-CAPTURE -> all outputs return to reset values on the next edge. A later arm and capture completes normally; with ADC_FORCE_TRIG_EN, force_trig in ARMED captures a DC input of 0x2000 as 0 values.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture
//
// Captures a fixed-length record of ADC samples after a level-crossing
// trigger and streams the record out over a valid/ready read port.
// Everything runs in the ADC sample clock domain.
//
// Build option: define ADC_FORCE_TRIG_EN to add the force_trig_i input.
// While the block is armed, force_trig_i starts a capture unconditionally.
//
// Ports
//   clk_i           sample clock, rising edge
//   reset_n_i       asynchronous active-low reset
//   adc_data_i      raw offset-binary ADC word
//   adc_otr_i       ADC overrange pin
//   arm_i           single-cycle arm request, honoured only in IDLE
//   trig_level_i    signed trigger threshold
//   trig_falling_i  0 = rising-edge trigger, 1 = falling-edge trigger
//   capture_len_i   record length; 0 or > DEPTH means DEPTH
//   otr_clear_i     clears otr_sticky_o
//   force_trig_i    (ADC_FORCE_TRIG_EN only) immediate trigger in ARMED
//   busy_o          high in ARMED, CAPTURE and READOUT
//   done_o          one-cycle pulse after the last sample is accepted
//   otr_sticky_o    overrange seen during capture
//   rd_data_o       signed sample
//   rd_valid_o      rd_data_o is valid
//   rd_ready_i      reader accepts the sample
//   rd_last_o       final sample of the record
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for arm
//   S_ARMED   | watching for a trigger; the trigger sample goes to address 0
//   S_CAPTURE | writing one sample per cycle until the record is full
//   S_READOUT | streaming addresses 0..len-1 to the reader

module adc_capture #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [DATA_W-1:0]        adc_data_i,
    input  logic                     adc_otr_i,
    input  logic                     arm_i,
    input  logic signed [DATA_W-1:0] trig_level_i,
    input  logic                     trig_falling_i,
    input  logic [ADDR_W:0]          capture_len_i,
    input  logic                     otr_clear_i,
`ifdef ADC_FORCE_TRIG_EN
    input  logic                     force_trig_i,
`endif
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     otr_sticky_o,
    output logic signed [DATA_W-1:0] rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic                     rd_last_o
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------
    // Free-running input stage: offset binary -> two's complement.
    // Runs in every state so s0_prev_q is always a real previous sample.
    // ---------------------------------------------------------------
    logic signed [DATA_W-1:0] s0_q, s0_prev_q;
    logic                     otr_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s0_q      <= '0;
            s0_prev_q <= '0;
            otr_q     <= 1'b0;
        end else begin
            s0_q      <= {~adc_data_i[DATA_W-1], adc_data_i[DATA_W-2:0]};
            s0_prev_q <= s0_q;
            otr_q     <= adc_otr_i;
        end
    end

    // ---------------------------------------------------------------
    // Trigger detection
    // ---------------------------------------------------------------
    logic level_hit;
    logic trig;

    always_comb begin
        if (trig_falling_i) begin
            level_hit = (s0_prev_q > trig_level_i) && (s0_q <= trig_level_i);
        end else begin
            level_hit = (s0_prev_q < trig_level_i) && (s0_q >= trig_level_i);
        end
    end

`ifdef ADC_FORCE_TRIG_EN
    assign trig = level_hit | force_trig_i;
`else
    assign trig = level_hit;
`endif

    // ---------------------------------------------------------------
    // Record buffer: single write port, registered read (1-cycle latency).
    // Not reset, so contents survive reset.
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_q;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= s0_q;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // ---------------------------------------------------------------
    // Control and readout registers
    // ---------------------------------------------------------------
    logic [ADDR_W:0]          len_q, len_d;
    logic [ADDR_W:0]          wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]          rd_ptr_q, rd_ptr_d;
    logic                     infl_q, infl_d;          // RAM read in flight
    logic                     infl_last_q, infl_last_d;
    logic                     out_v_q, out_v_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     skid_v_q, skid_v_d;
    logic [DATA_W-1:0]        skid_data_q, skid_data_d;
    logic                     skid_last_q, skid_last_d;
    logic                     done_q, done_d;
    logic                     sticky_q, sticky_d;

    logic                     pop;
    logic [1:0]               slots;
    logic                     issue;
    logic                     arm_take;
    logic                     otr_set;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            done_q      <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            done_q      <= done_d;
            sticky_q    <= sticky_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        infl_d      = 1'b0;
        infl_last_d = infl_last_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_cnt_q[ADDR_W-1:0];
        rd_en       = 1'b0;
        rd_addr     = rd_ptr_q[ADDR_W-1:0];
        pop         = out_v_q & rd_ready_i;
        issue       = 1'b0;
        // Entries that will be occupied once the pending read lands and the
        // current pop (if any) is taken; a new read may issue only if a slot
        // will still be free when it returns.
        slots       = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, infl_q}
                      - {1'b0, pop};
        arm_take    = (state_q == S_IDLE) && arm_i;

        unique case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    if ((capture_len_i == '0) || (capture_len_i > DEPTH_L)) begin
                        len_d = DEPTH_L;
                    end else begin
                        len_d = capture_len_i;
                    end
                    wr_cnt_d = '0;
                    rd_ptr_d = '0;
                    state_d  = S_ARMED;
                end
            end

            S_ARMED: begin
                if (trig) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_cnt_d = ONE_L;
                    state_d  = (len_q == ONE_L) ? S_READOUT : S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + ONE_L;
                if (wr_cnt_q == len_q - ONE_L) begin
                    state_d = S_READOUT;
                end
            end

            S_READOUT: begin
                issue = (rd_ptr_q < len_q) && (slots < 2'd2);
                if (issue) begin
                    rd_en       = 1'b1;
                    rd_ptr_d    = rd_ptr_q + ONE_L;
                    infl_d      = 1'b1;
                    infl_last_d = (rd_ptr_q == len_q - ONE_L);
                end

                if (pop) begin
                    if (skid_v_q) begin
                        out_data_d = skid_data_q;
                        out_last_d = skid_last_q;
                        skid_v_d   = 1'b0;
                    end else begin
                        out_v_d = 1'b0;
                    end
                end

                if (infl_q) begin
                    if (!out_v_d) begin
                        out_v_d    = 1'b1;
                        out_data_d = ram_q;
                        out_last_d = infl_last_q;
                    end else begin
                        skid_v_d    = 1'b1;
                        skid_data_d = ram_q;
                        skid_last_d = infl_last_q;
                    end
                end

                if (pop && out_last_q) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    out_v_d  = 1'b0;
                    skid_v_d = 1'b0;
                    infl_d   = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Overrange counts from the trigger sample through the last write.
        otr_set  = otr_q && ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && trig));
        sticky_d = otr_set | (sticky_q & ~otr_clear_i & ~arm_take);
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign otr_sticky_o = sticky_q;
    assign rd_data_o    = out_data_q;
    assign rd_valid_o   = out_v_q;
    assign rd_last_o    = out_last_q;

endmodule
